// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a combinational
// instruction memory and registers the result into the IF/ID stage.
// Supports stall, redirect with one delay slot, halt at PC 0 and a
// sticky misaligned-target fault.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [31:0]            instr_address,
  input  logic [31:0]            instr_readdata,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  output logic [31:0]            instr_out,
  output logic [31:0]            pc_out,
  output logic                   instr_valid,
  output logic                   halted,
  output logic                   misaligned_fault,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  logic [31:0] pc;
  logic        pend_vld;
  logic [31:0] pend_tgt;
  logic [31:0] next_pc;
  logic        bad_tgt;
  logic        pc_zero;
  logic        advance;

  assign instr_address = pc;
  assign bad_tgt       = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign pc_zero       = (pc == 32'h0);
  // A fetch from address 0 is never latched; it is treated as a halt.
  assign advance       = !stall && !halted && !pc_zero && !bad_tgt;

  // Next PC: a live redirect wins over a pending one, else sequential.
  always_comb begin
    next_pc = pc + 32'd4;
    if (redirect_valid)
      next_pc = redirect_target;
    else if (pend_vld)
      next_pc = pend_tgt;
  end

  // PC, IF/ID register, pending redirect, halt/fault and fetch counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc               <= RESET_VECTOR;
      pend_vld         <= 1'b0;
      pend_tgt         <= 32'h0;
      instr_out        <= 32'h0;
      pc_out           <= 32'h0;
      instr_valid      <= 1'b0;
      halted           <= 1'b0;
      misaligned_fault <= 1'b0;
      fetch_count      <= '0;
    end else if (halted) begin
      // Frozen: everything holds, redirects are ignored.
      instr_valid <= 1'b0;
    end else if (bad_tgt) begin
      // Misaligned redirect faults even when stalled; pc stays put.
      misaligned_fault <= 1'b1;
      halted           <= 1'b1;
      instr_valid      <= 1'b0;
    end else if (pc_zero) begin
      halted      <= 1'b1;
      instr_valid <= 1'b0;
    end else if (stall) begin
      // Hold the stage; remember the latest redirect for the release edge.
      if (redirect_valid) begin
        pend_vld <= 1'b1;
        pend_tgt <= redirect_target;
      end
    end else if (advance) begin
      instr_out   <= instr_readdata;
      pc_out      <= pc;
      instr_valid <= 1'b1;
      if (fetch_count != {COUNT_WIDTH{1'b1}})
        fetch_count <= fetch_count + 1'b1;
      pc       <= next_pc;
      pend_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected IF/ID
// contents, a negedge monitor pops and compares each newly latched fetch.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        halted;
  logic        misaligned_fault;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_cnt = 32'h0;

  instr_fetch_unit #(.RESET_VECTOR(32'hBFC00000), .COUNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .halted(halted), .misaligned_fault(misaligned_fault),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: two directed words, a distinct pattern elsewhere.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'hBFC00000: mem = 32'h24020005;
      32'hBFC00004: mem = 32'h24030007;
      default:      mem = {a[15:0], ~a[15:0]};
    endcase
  endfunction

  assign instr_readdata = mem(instr_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic [31:0] c);
    exp_t e;
    e.pc = p; e.instr = i; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a changed fetch_count with valid set marks a newly latched word.
  always @(negedge clk) begin
    if (reset_n && instr_valid && fetch_count !== last_cnt) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fetch actual pc_out=%h required none", pc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc_out", pc_out, e.pc);
        chk("sb_instr_out", instr_out, e.instr);
        chk("sb_fetch_count", fetch_count, e.cnt);
      end
    end
    last_cnt = fetch_count;
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    #12;
    chk("rst_addr", instr_address, 32'hBFC00000);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    reset_n = 1'b1;

    // Sequential fetch, then branch at BFC00008 with delay slot.
    push(32'hBFC00000, 32'h24020005, 1);
    push(32'hBFC00004, 32'h24030007, 2);
    push(32'hBFC00008, 32'h0008FFF7, 3);
    tick(3);
    redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
    push(32'hBFC0000C, 32'h000CFFF3, 4);
    tick(1);
    redirect_valid = 1'b0;
    push(32'hBFC00100, 32'h0100FEFF, 5);
    tick(1);

    // Stall three cycles with a redirect captured in the first.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hBFC00200;
    tick(1);
    redirect_valid = 1'b0;
    tick(2);
    chk("stall_pc_out", pc_out, 32'hBFC00100);
    chk("stall_count", fetch_count, 32'd5);
    chk("stall_addr", instr_address, 32'hBFC00104);
    stall = 1'b0;
    push(32'hBFC00104, 32'h0104FEFB, 6);
    push(32'hBFC00200, 32'h0200FDFF, 7);
    tick(2);

    // Jump to zero: delay slot latched, then halt.
    redirect_valid = 1'b1; redirect_target = 32'h0;
    push(32'hBFC00204, 32'h0204FDFB, 8);
    tick(1);
    redirect_valid = 1'b0;
    chk("zero_addr", instr_address, 32'h0);
    chk("zero_not_yet_halted", {31'h0, halted}, 32'h0);
    tick(1);
    chk("zero_halted", {31'h0, halted}, 32'h1);
    chk("zero_valid", {31'h0, instr_valid}, 32'h0);
    chk("zero_count", fetch_count, 32'd8);
    redirect_valid = 1'b1; redirect_target = 32'hBFC00300;
    tick(1);
    redirect_valid = 1'b0;
    chk("halt_ignore_addr", instr_address, 32'h0);
    chk("halt_ignore_count", fetch_count, 32'd8);

    // Async reset out of halt, then misaligned redirect.
    reset_n = 1'b0;
    #1;
    chk("rst2_halted", {31'h0, halted}, 32'h0);
    chk("rst2_addr", instr_address, 32'hBFC00000);
    chk("rst2_count", fetch_count, 32'h0);
    reset_n = 1'b1;
    push(32'hBFC00000, 32'h24020005, 1);
    tick(1);
    redirect_valid = 1'b1; redirect_target = 32'hBFC00102;
    tick(1);
    redirect_valid = 1'b0;
    chk("mis_fault", {31'h0, misaligned_fault}, 32'h1);
    chk("mis_halted", {31'h0, halted}, 32'h1);
    chk("mis_addr", instr_address, 32'hBFC00004);
    chk("mis_count", fetch_count, 32'd1);

    // Reset mid-stall with a pending redirect.
    reset_n = 1'b0;
    #1;
    chk("rst3_fault", {31'h0, misaligned_fault}, 32'h0);
    reset_n = 1'b1;
    push(32'hBFC00000, 32'h24020005, 1);
    push(32'hBFC00004, 32'h24030007, 2);
    tick(2);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hBFC00400;
    tick(1);
    redirect_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst4_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst4_count", fetch_count, 32'h0);
    chk("rst4_addr", instr_address, 32'hBFC00000);
    chk("rst4_pc_out", pc_out, 32'h0);
    reset_n = 1'b1; stall = 1'b0;
    push(32'hBFC00000, 32'h24020005, 1);
    push(32'hBFC00004, 32'h24030007, 2);
    tick(2);
    chk("post_rst_addr", instr_address, 32'hBFC00008);
    tick(1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction memory interface: owns the PC, drives instr_address and consumes instr_readdata.
- Instruction memory responds combinationally, so each fetch completes in the same cycle it is addressed.
- Registers the fetched word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with one MIPS delay slot, halt on reaching address 0, and misaligned-target fault.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- COUNT_WIDTH, 32, width of the saturating fetch counter.

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous active-low reset
- instr_address  output  32  byte address to instruction memory; equals the current PC
- instr_readdata  input  32  word returned by instruction memory for instr_address, same cycle
- stall  input  1  hold the IF/ID register and PC this cycle
- redirect_valid  input  1  branch/jump in decode is taken; one-cycle pulse
- redirect_target  input  32  byte target for redirect_valid
- instr_out  output  32  IF/ID instruction register
- pc_out  output  32  address instr_out was fetched from
- instr_valid  output  1  instr_out holds a real fetched instruction
- halted  output  1  fetch stopped: PC reached 0 or fault
- misaligned_fault  output  1  sticky; a redirect target had bits [1:0] != 0
- fetch_count  output  COUNT_WIDTH  number of instructions latched into IF/ID, saturating

Behaviour:
- Reset (asynchronous, reset_n=0) sets:
  - pc = RESET_VECTOR
  - instr_out = 0 (NOP), pc_out = 0, instr_valid = 0
  - halted = 0, misaligned_fault = 0, fetch_count = 0
  - pending redirect cleared
- Reset mid-operation discards any pending redirect and the in-flight fetch.
- instr_address = pc, combinationally, at all times, including while halted.
- Advance condition: reset_n=1 and stall=0 and halted=0. On each rising edge where it holds:
  - instr_out <= instr_readdata
  - pc_out <= pc
  - instr_valid <= 1
  - fetch_count <= fetch_count+1, saturating at all-ones
  - pc <= next_pc
- next_pc:
  - If redirect_valid, redirect_target.
  - Else if a redirect is pending, the pending target; pending is cleared.
  - Else pc+4, modulo 2^32.
- Delay slot: redirect_valid is raised while the branch sits in instr_out. The word being fetched in that same cycle, at branch PC+4, is the delay slot and is always latched. The target is fetched next. No flush is ever performed.
- Stall:
  - PC, instr_out, pc_out, instr_valid and fetch_count all hold.
  - If redirect_valid=1 during the stall, the target is captured into the pending register and applied on the first unstalled edge.
  - A second redirect during the same stall window replaces the pending target.
  - Redirect and stall in the same cycle are both honoured: capture the target, hold everything else.
- Misaligned target (redirect_target[1:0] != 0 when redirect_valid=1):
  - misaligned_fault <= 1 and halted <= 1 on that edge, even if stalled.
  - pc is not updated.
- Halt on zero:
  - When pc == 0 (from a redirect or from wrap of 32'hFFFFFFFC+4), halted is set combinationally-registered: halted <= 1 on the edge after pc becomes 0.
  - No fetch from address 0 is latched: the advance condition treats pc==0 as halted.
  - instr_valid <= 0 on that edge.
- While halted, all registers hold except instr_valid, which is 0. Only reset clears halted and misaligned_fault.
- Redirect inputs are ignored while halted.

Test Plan:
- Reset release, memory holds 32'h24020005 at 0xBFC00000 and 32'h24030007 at 0xBFC00004, no stall.
  -> instr_address=0xBFC00000 before the first edge.
  -> After edge 1: instr_out=24020005, pc_out=BFC00000, valid=1.
  -> After edge 2: instr_out=24030007, pc_out=BFC00004, fetch_count=2.
- Branch at BFC00008 in instr_out, redirect_valid=1, target=BFC00100.
  -> Next latched pc_out=BFC0000C (delay slot), then BFC00100.
- stall=1 for 3 cycles with redirect_valid pulsed in stall cycle 1, target=BFC00200.
  -> Outputs and fetch_count frozen for 3 edges.
  -> First unstalled edge latches the pending-slot word; the following edge fetches BFC00200.
- Redirect to 0x00000000 (jr to zero).
  -> Delay slot latched, then halted=1, instr_valid=0, fetch_count frozen.
  -> Further redirects ignored; instr_address stays 0.
- Redirect target BFC00102.
  -> misaligned_fault=1 and halted=1 after the edge; pc unchanged.
- Assert reset_n=0 mid-stall with a pending redirect.
  -> All outputs return to reset values immediately, without a clock edge.
  -> After release, the first fetch is from RESET_VECTOR, not the pending target.
